// File: rtl/mmul_pkg.sv
// Shared encodings for the bit-serial modular multiplier sequencer and its datapath.
package mmul_pkg;

  localparam logic [1:0] FLAG_REGC = 2'b00;
  localparam logic [1:0] FLAG_REGD = 2'b01;
  localparam logic [1:0] FLAG_REGB = 2'b10;

  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_DBL_ADD = 2'b01;
  localparam logic [1:0] OP_SUB     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ADD,
    ST_SUB1,
    ST_SUB2,
    ST_DONE
  } mmul_state_e;

  // Register that receives the next result: regc -> regd -> regb -> regc; illegal 11 folds to regc.
  function automatic logic [1:0] next_loc(input logic [1:0] flag);
    case (flag)
      FLAG_REGC: return FLAG_REGD;
      FLAG_REGD: return FLAG_REGB;
      default:   return FLAG_REGC;
    endcase
  endfunction

endpackage

// File: rtl/mmul_seq_ctrl.sv
// Sequencer for the bit-serial interleaved modular multiplier (MSB first).
// Build option MMUL_EARLY_EXIT_EN: skip the second subtraction when the first one borrows.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | pulse mmul_en, clear regc, load flag 00
// ADD   | dst = 2*src + a[bit_idx]*b
// SUB1  | first conditional dst = src - p
// SUB2  | second conditional dst = src - p, then next bit or finish
// DONE  | one-cycle done pulse, src_sel shows final c location
module mmul_seq_ctrl
  import mmul_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       c_flag,
  input  logic             borrow,
  output logic             busy,
  output logic             done,
  output logic             mmul_en,
  output logic             clr_c,
  output logic [1:0]       op,
  output logic [1:0]       src_sel,
  output logic [1:0]       dst_sel,
  output logic             dst_we,
  output logic             c_flag_we,
  output logic [1:0]       c_flag_in,
  output logic [CNT_W-1:0] bit_idx
);

  mmul_state_e      state_q, state_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic             last_bit;

  assign last_bit = (bit_idx_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    busy      = 1'b1;
    done      = 1'b0;
    mmul_en   = 1'b0;
    clr_c     = 1'b0;
    op        = OP_NONE;
    dst_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = ST_INIT;
          bit_idx_d = CNT_W'(WIDTH - 1);
        end
      end
      ST_INIT: begin
        mmul_en = 1'b1;
        clr_c   = 1'b1;
        state_d = ST_ADD;
      end
      ST_ADD: begin
        op      = OP_DBL_ADD;
        dst_we  = 1'b1;
        state_d = ST_SUB1;
      end
      ST_SUB1: begin
        op      = OP_SUB;
        dst_we  = ~borrow;
`ifdef MMUL_EARLY_EXIT_EN
        if (borrow) begin
          if (last_bit) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_ADD;
            bit_idx_d = bit_idx_q - CNT_W'(1);
          end
        end else begin
          state_d = ST_SUB2;
        end
`else
        state_d = ST_SUB2;
`endif
      end
      ST_SUB2: begin
        op     = OP_SUB;
        dst_we = ~borrow;
        if (last_bit) begin
          state_d = ST_DONE;
        end else begin
          state_d   = ST_ADD;
          bit_idx_d = bit_idx_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register selects are held at 0 while idle so every output is 0 in and after reset.
  assign src_sel   = busy ? c_flag : 2'b00;
  assign dst_sel   = busy ? next_loc(c_flag) : 2'b00;
  assign c_flag_we = dst_we;
  assign c_flag_in = dst_sel;
  assign bit_idx   = bit_idx_q;

endmodule
